// File: rtl/bus_arbiter_driver_if.sv
// rtl/bus_arbiter_driver_if.sv - request/bus handshake bundle for bus_arbiter_driver
interface bus_arbiter_driver_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4
);
  logic [NSRC-1:0]       req;
  logic [NSRC*WIDTH-1:0] data_in;
  logic [NSRC-1:0]       ack;
  logic [NSRC-1:0]       grant;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic                  bus_ready;
  logic                  oe;
  wire  [WIDTH-1:0]      bus_tri;

  modport master (
    input  req, data_in, bus_ready, oe,
    output ack, grant, bus_out, bus_valid, bus_tri
  );

  modport slave (
    output req, data_in, bus_ready, oe,
    input  ack, grant, bus_out, bus_valid, bus_tri
  );
endinterface

// File: rtl/bus_arbiter_driver.sv
// rtl/bus_arbiter_driver.sv - round-robin arbiter driving a registered, tristate-gated result bus
module bus_arbiter_driver #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bus_arbiter_driver_if.master  bif
);
  localparam int PW = $clog2(NSRC);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [PW-1:0]     last;
  logic [NSRC-1:0]   mask;
  logic [NSRC-1:0]   ack_r;
  logic [NSRC-1:0]   grant_r;
  logic [WIDTH-1:0]  out_r;

  logic              load;
  logic [NSRC-1:0]   elig;
  logic              found;
  logic [PW-1:0]     winner;
  logic [PW:0]       probe;
  logic [NSRC-1:0]   win_onehot;
  logic [WIDTH-1:0]  win_data;

  assign load = (state == IDLE) || bif.bus_ready;
  assign elig = bif.req & ~mask;

  // Search starts one past the last winner and wraps modulo NSRC.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    probe  = '0;
    for (int k = 1; k <= NSRC; k++) begin
      probe = {1'b0, last} + (PW+1)'(k);
      if (probe >= (PW+1)'(NSRC))
        probe = probe - (PW+1)'(NSRC);
      if (!found && elig[probe[PW-1:0]]) begin
        found  = 1'b1;
        winner = probe[PW-1:0];
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    win_data   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (winner == PW'(i)) begin
        win_onehot[i] = 1'b1;
        win_data      = bif.data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= PW'(NSRC-1);
      mask    <= '0;
      ack_r   <= '0;
      grant_r <= '0;
      out_r   <= '0;
    end else if (load) begin
      if (found) begin
        state   <= BUSY;
        out_r   <= win_data;
        grant_r <= win_onehot;
        ack_r   <= win_onehot;
        last    <= winner;
        // Fresh winner sits out the next edge so it can refresh data or drop req.
        mask    <= win_onehot;
      end else begin
        state   <= IDLE;
        grant_r <= '0;
        ack_r   <= '0;
        mask    <= '0;
      end
    end else begin
      ack_r <= '0;
      mask  <= '0;
    end
  end

  assign bif.ack       = ack_r;
  assign bif.grant     = grant_r;
  assign bif.bus_out   = out_r;
  assign bif.bus_valid = (state == BUSY);
  assign bif.bus_tri   = (bif.oe && (state == BUSY)) ? out_r : {WIDTH{1'bz}};
endmodule

// File: tb/tb_bus_arbiter_driver.sv
// tb/tb_bus_arbiter_driver.sv - directed and randomized bench for bus_arbiter_driver
module tb_bus_arbiter_driver;
  localparam int WIDTH = 32;
  localparam int NSRC  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_driver_if #(.WIDTH(WIDTH), .NSRC(NSRC)) bif ();

  bus_arbiter_driver #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  logic [WIDTH-1:0] d [NSRC];

  // Reference state: indices, -1 meaning none.
  int               m_last;
  int               m_mask;
  int               m_grant;
  int               m_ack;
  bit               m_valid;
  logic [WIDTH-1:0] m_out;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [NSRC-1:0] oh(int i);
    logic [NSRC-1:0] one;
    one = 1;
    if (i < 0) return '0;
    return one << i;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NSRC; i++)
      bif.data_in[i*WIDTH +: WIDTH] = d[i];
  endtask

  task automatic model_reset();
    m_last  = NSRC - 1;
    m_mask  = -1;
    m_grant = -1;
    m_ack   = -1;
    m_valid = 0;
    m_out   = '0;
  endtask

  task automatic model_edge();
    int w;
    w = -1;
    if (!m_valid || bif.bus_ready) begin
      for (int k = 1; k <= NSRC; k++) begin
        int i;
        i = (m_last + k) % NSRC;
        if (w < 0 && bif.req[i] && i != m_mask) w = i;
      end
      if (w >= 0) begin
        m_out   = d[w];
        m_grant = w;
        m_ack   = w;
        m_valid = 1;
        m_last  = w;
        m_mask  = w;
      end else begin
        m_valid = 0;
        m_grant = -1;
        m_ack   = -1;
        m_mask  = -1;
      end
    end else begin
      m_ack  = -1;
      m_mask = -1;
    end
  endtask

  task automatic chk(string tag, logic [WIDTH-1:0] obs, logic [WIDTH-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    logic [WIDTH-1:0] etri;
    etri = (bif.oe && m_valid) ? m_out : {WIDTH{1'bz}};
    chk({tag, "_valid"}, WIDTH'(bif.bus_valid), WIDTH'(m_valid));
    chk({tag, "_out"},   bif.bus_out, m_out);
    chk({tag, "_grant"}, WIDTH'(bif.grant), WIDTH'(oh(m_grant)));
    chk({tag, "_ack"},   WIDTH'(bif.ack), WIDTH'(oh(m_ack)));
    chk({tag, "_tri"},   bif.bus_tri, etri);
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #2;
    check_all(tag);
  endtask

  task automatic mid_reset(string tag);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NSRC; i++) d[i] = '0;
    drive_data();
    bif.req = '0;
    bif.bus_ready = 1'b0;
    bif.oe = 1'b0;
    model_reset();
    #22 rst = 1'b0;
    check_all("reset");

    // Single request, then idle.
    d[0] = 32'h00CD00AA; drive_data();
    bif.req = 4'b0001; bif.bus_ready = 1'b1;
    tick("single");
    chk("single_exact", bif.bus_out, 32'h00CD00AA);
    bif.req = 4'b0000;
    tick("single_idle");

    // Round-robin from a fresh reset.
    mid_reset("rr_reset");
    for (int i = 0; i < NSRC; i++) d[i] = 32'hFF00AAB0 + i;
    drive_data();
    bif.req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick("rr");
      chk("rr_order", WIDTH'(bif.grant), WIDTH'(oh(c % NSRC)));
    end

    // Backpressure.
    mid_reset("bp_reset");
    d[1] = 32'hFAB44567; d[2] = 32'h12345678; drive_data();
    bif.req = 4'b0010; bif.bus_ready = 1'b0;
    tick("bp_load");
    bif.req = 4'b0110;
    for (int c = 0; c < 3; c++) tick("bp_hold");
    chk("bp_held_word", bif.bus_out, 32'hFAB44567);
    bif.bus_ready = 1'b1;
    tick("bp_release");
    chk("bp_next", WIDTH'(bif.grant), WIDTH'(4'b0100));

    // Turnaround mask with a lone requester.
    bif.req = 4'b0000;
    tick("ta_drain");
    bif.req = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      tick("ta");
      chk("ta_toggle", WIDTH'(bif.bus_valid), WIDTH'((c % 2) == 0));
    end

    // Tristate gating.
    mid_reset("tri_reset");
    d[0] = 32'h00CD44AA; drive_data();
    bif.req = 4'b0001; bif.bus_ready = 1'b0; bif.oe = 1'b0;
    tick("tri_oe0");
    bif.oe = 1'b1;
    #1 check_all("tri_oe1");
    chk("tri_drive", bif.bus_tri, 32'h00CD44AA);
    bif.req = 4'b0000; bif.bus_ready = 1'b1;
    tick("tri_idle");

    // Async reset while busy, then lowest-indexed requester wins.
    bif.req = 4'b1111;
    tick("ar_busy");
    mid_reset("ar_mid");
    bif.req = 4'b1010;
    tick("ar_after");
    chk("ar_first", WIDTH'(bif.grant), WIDTH'(4'b0010));

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NSRC; i++) d[i] = $urandom;
      drive_data();
      bif.req       = NSRC'($urandom);
      bif.bus_ready = ($urandom_range(3) != 0);
      bif.oe        = $urandom_range(1);
      tick("rand");
      if ($urandom_range(39) == 0) mid_reset("rand_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_driver.md
Name: bus_arbiter_driver

Overview:
- Parametrised successor to the ALU's 32-bit tristate buffer.
- NSRC requesters share one WIDTH-bit result bus through a round-robin arbiter.
- The granted word is registered and held under a valid/ready handshake, and is also presented on a tristate bus gated by an output enable.
- Sits between the ALU/regfile sources and the shared writeback bus.

Parameters:
WIDTH, 32, data width of each source and of the bus
NSRC, 4, number of requesting sources (2..16)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req  input  NSRC  per-source request; bit i high = data_in slice i is valid
data_in  input  NSRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
ack  output  NSRC  one-hot, one-cycle pulse: source i's word was captured
grant  output  NSRC  one-hot owner of the word currently on bus_out; 0 when idle
bus_out  output  WIDTH  registered bus word
bus_valid  output  1  bus_out holds an untaken word
bus_ready  input  1  consumer accepts bus_out this cycle
oe  input  1  tristate output enable
bus_tri  output  WIDTH  bus_out when (oe && bus_valid), else all 'z

Behaviour:
- Reset (asynchronous, any time, including mid-transfer) forces:
  - ack=0, grant=0, bus_out=0, bus_valid=0 (state IDLE).
  - Round-robin pointer last=NSRC-1, so source 0 has highest priority first.
  - Mask register=0.
- States: IDLE (bus_valid=0) and BUSY (bus_valid=1).
- Load condition: load = !bus_valid || bus_ready.
- Eligible set: elig = req & ~mask.
- At a rising edge with load=1 and elig!=0:
  - Winner w is the first set bit of elig searching last+1, last+2, ... modulo NSRC.
  - bus_out <= data_in[w], grant <= onehot(w), ack <= onehot(w), bus_valid <= 1, last <= w, mask <= onehot(w).
  - Next state BUSY.
- At a rising edge with load=1 and elig==0:
  - bus_valid <= 0, grant <= 0, ack <= 0, mask <= 0; bus_out holds its value.
  - Next state IDLE.
- At a rising edge with load=0 (BUSY, bus_ready=0):
  - bus_out, grant, bus_valid and last hold; ack <= 0; mask <= 0.
- Turnaround rule: a source acked at edge E is ineligible at edge E+1, which gives it one cycle to update data or drop req.
  - Per-source peak rate: 1 word per 2 cycles.
  - Aggregate rate: 1 word per cycle when two or more sources request.
- Back-to-back: in BUSY with bus_ready=1 and another eligible request, the new word replaces the old at the same edge. bus_valid stays 1 with no bubble.
- req must be held until ack. A source that drops req before ack is simply not granted; no error is raised.
- bus_tri is combinational from oe, bus_valid and bus_out. It never drives while bus_valid=0.
- Width rules:
  - The pointer is $clog2(NSRC) bits.
  - Wrap from NSRC-1 to 0 is modulo NSRC.
  - For non-power-of-two NSRC, pointer values >= NSRC never occur.
- Latency: req to bus_valid/ack is 1 cycle when the bus is free.

Test Plan:
- Reset then single request: rst pulse; req=4'b0001, data_in[0]='h00CD00AA, bus_ready=1 -> next edge: bus_out='h00CD00AA, bus_valid=1, grant=ack=4'b0001; req dropped -> following edge: bus_valid=0, grant=0.
- Round-robin fairness: req=4'b1111 held, data_in[i]='hFF00AAB0+i, bus_ready=1 -> grants 0,1,2,3,0,... one per cycle, bus_valid continuously 1, bus_out tracks data_in of each grantee.
- Backpressure: BUSY with bus_out='hFAB44567, bus_ready=0 for 3 cycles while req=4'b0110 -> bus_out, grant and bus_valid unchanged, ack=0; bus_ready=1 -> next winner loaded on that edge.
- Turnaround mask: only req[2]=1 held continuously, bus_ready=1 -> ack[2] pulses every other cycle and bus_valid toggles 1,0,1,0.
- Tristate: bus_valid=1, bus_out='h00CD44AA; oe=0 -> bus_tri all z; oe=1 -> bus_tri='h00CD44AA; bus_valid=0 with oe=1 -> all z.
- Async reset mid-transfer: assert rst between edges while BUSY -> bus_valid, grant, ack and bus_out go 0 immediately, without waiting for a clock edge; after release, first grant goes to the lowest-indexed requester.
